// File: rtl/mdu_pkg.sv
// Shared constants and types for the multiply/divide unit and the control decoder.
// Optional feature macro: MDU_DIV_EN (restoring divider; mult-only when undefined).
package mdu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ITER  = 32;
    localparam int unsigned CNT_W = 5;

    // op encoding
    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    // move encoding (hi/lo read select)
    localparam logic [1:0] MOVE_HI = 2'b01;
    localparam logic [1:0] MOVE_LO = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/mdu_sign_fix.sv
// Operand magnitudes and sign correction of the unsigned result.
// Optional feature macro: MDU_DIV_EN (adds quotient/remainder correction).
module mdu_sign_fix
    import mdu_pkg::*;
(
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    input  logic [2*XLEN-1:0] mag_res,
    input  logic              sign_x,
`ifdef MDU_DIV_EN
    input  logic              op_div,
    input  logic              sign_a,
`endif
    output logic [XLEN-1:0]   mag_a,
    output logic [XLEN-1:0]   mag_b,
    output logic [XLEN-1:0]   res_hi,
    output logic [XLEN-1:0]   res_lo
);

    logic [2*XLEN-1:0] prod;

    // Absolute values of the operands and signed form of the result
    always_comb begin
        mag_a = a[XLEN-1] ? XLEN'(-a) : a;
        mag_b = b[XLEN-1] ? XLEN'(-b) : b;
        prod  = sign_x ? (2*XLEN)'(-mag_res) : mag_res;
        {res_hi, res_lo} = prod;
`ifdef MDU_DIV_EN
        if (op_div == OP_DIV) begin
            // quotient takes a^b sign, remainder takes the dividend sign
            res_lo = sign_x ? XLEN'(-mag_res[XLEN-1:0]) : mag_res[XLEN-1:0];
            res_hi = sign_a ? XLEN'(-mag_res[2*XLEN-1:XLEN]) : mag_res[2*XLEN-1:XLEN];
        end
`endif
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit with architectural HI/LO registers.
// Optional feature macro: MDU_DIV_EN (when undefined, div requests set err).
module mult_div_unit
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [1:0]      move,
    output logic [XLEN-1:0] rdata,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*XLEN-1:0]  w;
    logic [2*XLEN-1:0]  w_next;
    logic [XLEN-1:0]    mb;
    logic               sign_x;
    logic               skip;
    logic               reject;
    logic [XLEN-1:0]    mag_a;
    logic [XLEN-1:0]    mag_b;
    logic [XLEN-1:0]    res_hi;
    logic [XLEN-1:0]    res_lo;
    logic [XLEN:0]      sum;
`ifdef MDU_DIV_EN
    logic               op_q;
    logic               sign_a;
    logic [XLEN:0]      rem_sh;
    logic [XLEN-1:0]    diff;
`endif

    mdu_sign_fix u_sign_fix (
        .a       (a),
        .b       (b),
        .mag_res (w),
        .sign_x  (sign_x),
`ifdef MDU_DIV_EN
        .op_div  (op_q),
        .sign_a  (sign_a),
`endif
        .mag_a   (mag_a),
        .mag_b   (mag_b),
        .res_hi  (res_hi),
        .res_lo  (res_lo)
    );

    // Requests that complete immediately with err instead of iterating
`ifdef MDU_DIV_EN
    assign reject = (op == OP_DIV) && (b == '0);
`else
    assign reject = (op == OP_DIV);
`endif

    // HI/LO read port
    always_comb begin
        rdata = '0;
        if (move == MOVE_HI) rdata = hi;
        else if (move == MOVE_LO) rdata = lo;
    end

    // One iteration: shift-add multiply step, or restoring divide step
    always_comb begin
        sum    = {1'b0, w[2*XLEN-1:XLEN]} + (w[0] ? {1'b0, mb} : {(XLEN+1){1'b0}});
        w_next = {sum, w[XLEN-1:1]};
`ifdef MDU_DIV_EN
        rem_sh = {w[2*XLEN-1:XLEN], w[XLEN-1]};
        diff   = XLEN'(rem_sh - {1'b0, mb});
        if (op_q == OP_DIV) begin
            if (rem_sh >= {1'b0, mb}) w_next = {diff, w[XLEN-2:0], 1'b1};
            else                      w_next = {rem_sh[XLEN-1:0], w[XLEN-2:0], 1'b0};
        end
`endif
    end

    // Control FSM, iteration datapath and architectural registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            w      <= '0;
            mb     <= '0;
            sign_x <= 1'b0;
            skip   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
`ifdef MDU_DIV_EN
            op_q   <= OP_MULT;
            sign_a <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        err    <= 1'b0;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        w      <= {{XLEN{1'b0}}, mag_a};
                        mb     <= mag_b;
                        sign_x <= a[XLEN-1] ^ b[XLEN-1];
                        skip   <= reject;
`ifdef MDU_DIV_EN
                        op_q   <= op;
                        sign_a <= a[XLEN-1];
`endif
                        state  <= reject ? FIX : RUN;
                    end
                end
                RUN: begin
                    w   <= w_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(ITER - 1)) state <= FIX;
                end
                FIX: begin
                    if (skip) begin
                        err <= 1'b1;
                    end else begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: behavioural model plus directed and random ops.
// Honours MDU_DIV_EN the same way as the design build.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  move;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    bit chk_on = 0;

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .move  (move),
        .rdata (rdata),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        m_err, m_busy, m_done, pend, p_bad;
    int          edge_no = 0;
    int          pend_edge = 0;

    task automatic model_compute(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                                 output logic bad, output logic [31:0] rh, output logic [31:0] rl);
        longint sa, sb, p;
`ifdef MDU_DIV_EN
        longint q, r;
`endif
        sa = longint'($signed(a_i));
        sb = longint'($signed(b_i));
        bad = 1'b0;
        rh = '0;
        rl = '0;
        if (op_i == 1'b0) begin
            p  = sa * sb;
            rh = p[63:32];
            rl = p[31:0];
        end else begin
`ifdef MDU_DIV_EN
            if (b_i == 32'd0) begin
                bad = 1'b1;
            end else begin
                q  = sa / sb;
                r  = sa % sb;
                rl = q[31:0];
                rh = r[31:0];
            end
`else
            bad = 1'b1;
`endif
        end
    endtask

    // Model: result lands 33 edges after acceptance, rejected ops one edge after
    always @(posedge clk) begin
        edge_no++;
        if (!reset) begin
            m_hi = '0; m_lo = '0; m_err = 1'b0; m_busy = 1'b0; m_done = 1'b0; pend = 1'b0;
        end else begin
            m_done = 1'b0;
            if (pend) begin
                if (edge_no == pend_edge) begin
                    if (p_bad) m_err = 1'b1;
                    else begin m_hi = p_hi; m_lo = p_lo; end
                    m_done = 1'b1;
                    m_busy = 1'b0;
                    pend   = 1'b0;
                end
            end else if (start) begin
                model_compute(op, a, b, p_bad, p_hi, p_lo);
                m_err     = 1'b0;
                m_busy    = 1'b1;
                pend      = 1'b1;
                pend_edge = edge_no + (p_bad ? 1 : 33);
            end
        end
    end

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        logic [31:0] m_rd;
        if (chk_on) begin
            m_rd = (move == 2'b01) ? m_hi : (move == 2'b10) ? m_lo : 32'd0;
            check("busy",  64'(busy),  64'(m_busy));
            check("done",  64'(done),  64'(m_done));
            check("err",   64'(err),   64'(m_err));
            check("hi",    64'(hi),    64'(m_hi));
            check("lo",    64'(lo),    64'(m_lo));
            check("rdata", 64'(rdata), 64'(m_rd));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                               input logic [1:0] mv);
        #1;
        start = 1'b1; op = op_i; a = a_i; b = b_i; move = mv;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_n);
        int n;
        n = 0;
        busy_n = 0;
        lat = -1;
        while (1) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin lat = n + 1; break; end
            if (n >= 100) begin
                checks++;
                errors++;
                $display("FAIL timeout: no done after %0d cycles", n);
                break;
            end
            @(posedge clk);
            n++;
        end
    endtask

    initial begin
        int lat, bn, seen;
        logic [31:0] eh, el, ra, rb;
        logic        rop;
        reset = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0; move = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_on = 1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err",  64'(err),  64'd0);
        check("rst_hi",   64'(hi),   64'd0);
        check("rst_lo",   64'(lo),   64'd0);
        #1 reset = 1'b1;

        // 7 * -3
        pulse_start(1'b0, 32'd7, 32'hFFFF_FFFD, 2'b00);
        wait_done(lat, bn);
        check("mul7_hi",   64'(hi),  64'hFFFF_FFFF);
        check("mul7_lo",   64'(lo),  64'hFFFF_FFEB);
        check("mul7_lat",  64'(lat), 64'd34);
        check("mul7_busy", 64'(bn),  64'd33);

        // most-negative squared, then read back through rdata
        pulse_start(1'b0, 32'h8000_0000, 32'h8000_0000, 2'b00);
        wait_done(lat, bn);
        check("mulmin_hi", 64'(hi), 64'h4000_0000);
        check("mulmin_lo", 64'(lo), 64'h0);
        #1 move = 2'b01;
        @(negedge clk);
        check("rd_hi", 64'(rdata), 64'h4000_0000);
        #1 move = 2'b10;
        @(negedge clk);
        check("rd_lo", 64'(rdata), 64'h0);

`ifdef MDU_DIV_EN
        pulse_start(1'b1, 32'hFFFF_FFF9, 32'd2, 2'b00);
        wait_done(lat, bn);
        check("div7_lo",  64'(lo),  64'hFFFF_FFFD);
        check("div7_hi",  64'(hi),  64'hFFFF_FFFF);
        check("div7_err", 64'(err), 64'd0);
        check("div7_lat", 64'(lat), 64'd34);
        pulse_start(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00);
        wait_done(lat, bn);
        check("divwrap_lo",  64'(lo),  64'h8000_0000);
        check("divwrap_hi",  64'(hi),  64'h0);
        check("divwrap_err", 64'(err), 64'd0);
        eh = 32'h0; el = 32'h8000_0000;
`else
        pulse_start(1'b1, 32'hFFFF_FFF9, 32'd2, 2'b00);
        wait_done(lat, bn);
        check("nodiv_err", 64'(err), 64'd1);
        check("nodiv_hi",  64'(hi),  64'h4000_0000);
        check("nodiv_lo",  64'(lo),  64'h0);
        check("nodiv_lat", 64'(lat), 64'd2);
        eh = 32'h4000_0000; el = 32'h0;
`endif

        // divide by zero keeps HI/LO, next start clears err
        pulse_start(1'b1, 32'd1234, 32'd0, 2'b00);
        wait_done(lat, bn);
        check("div0_err", 64'(err), 64'd1);
        check("div0_hi",  64'(hi),  64'(eh));
        check("div0_lo",  64'(lo),  64'(el));
        check("div0_lat", 64'(lat), 64'd2);
        pulse_start(1'b0, 32'd3, 32'd5, 2'b00);
        @(negedge clk);
        check("err_clr", 64'(err), 64'd0);
        wait_done(lat, bn);
        check("mul35_lo", 64'(lo), 64'd15);

        // start while busy is ignored
        pulse_start(1'b0, 32'd100, 32'd200, 2'b00);
        repeat (9) @(posedge clk);
        #1 start = 1'b1; op = 1'b0; a = 32'd5; b = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bn);
        check("ovl_lo", 64'(lo), 64'd20000);
        check("ovl_hi", 64'(hi), 64'd0);

        // reset in the middle of an operation
        pulse_start(1'b0, 32'd9, 32'd9, 2'b00);
        repeat (19) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort_done", 64'(seen), 64'd0);
        check("abort_hi",   64'(hi),   64'd0);
        check("abort_lo",   64'(lo),   64'd0);
        check("abort_busy", 64'(busy), 64'd0);

        // random operations, often back-to-back in the done cycle
        for (int i = 0; i < 40; i++) begin
            rop = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: ra = 32'h8000_0000;
                1: ra = 32'hFFFF_FFFF;
                2: ra = 32'd0;
                3: ra = 32'($urandom_range(0, 50));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'h8000_0000;
                3: rb = 32'd1;
                default: rb = $urandom;
            endcase
            pulse_start(rop, ra, rb, 2'($urandom_range(0, 3)));
            wait_done(lat, bn);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, reset; synchronous, active-low.
REQ-003 SHALL have port start, input, 1, request pulse from the decode side (asserted for mult/div, move=11).
REQ-004 SHALL have port op, input, 1, 0=mult, 1=div; sampled with start.
REQ-005 SHALL have ports a and b, input, 32 each, rs and rt operands, two's complement, sampled with start.
REQ-006 SHALL have port move, input, 2, 01=mfhi read, 10=mflo read, other values give rdata=0.
REQ-007 SHALL have port rdata, output, 32, combinational hi/lo read selected by move.
REQ-008 SHALL have port busy, output, 1, high while an operation is in flight; the pipeline stalls on it.
REQ-009 SHALL have port done, output, 1, single-cycle completion pulse.
REQ-010 SHALL have port err, output, 1, sticky error flag (divide by zero, or div when not compiled), cleared by the next accepted start.
REQ-011 SHALL have ports hi and lo, output, 32 each, architectural HI/LO registers.

Function
REQ-012 SHALL use FSM states IDLE, RUN, FIX, with RUN lasting exactly 32 cycles counted by a 5-bit iteration counter.
REQ-013 SHALL accept start only in IDLE; start while busy SHALL be ignored with no state change.
REQ-014 On acceptance, SHALL latch the magnitudes of a and b plus the result signs, go to RUN, and assert busy on the next cycle.
REQ-015 mult SHALL be shift-add, one operand bit per RUN cycle, giving a 64-bit product magnitude.
REQ-016 div SHALL be restoring division, one quotient bit per RUN cycle.
REQ-017 FIX SHALL apply sign correction and write hi/lo:
- mult: {hi,lo} = signed 64-bit product.
- div: lo = quotient truncated toward zero; hi = remainder carrying the sign of a.
REQ-018 Timing SHALL be: start accepted at edge k, hi/lo written at edge k+33, done=1 and busy=0 in the cycle after edge k+33, then return to IDLE.
REQ-019 A new start SHALL be accepted in the done cycle.
REQ-020 div with b=0 SHALL skip RUN, leave hi/lo unchanged, set err, and pulse done in the cycle after edge k+1.
REQ-021 div of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0 (wrap, no error).
REQ-022 rdata SHALL reflect hi/lo written at the previous edge; values read while busy are the old HI/LO.

Reset
REQ-023 With reset=0 at a clock edge, the block SHALL go to IDLE and clear hi, lo, the counter and err; busy and done read 0 in the following cycle.
REQ-024 Reset mid-operation SHALL abort the operation with no hi/lo write and no done pulse.

Configuration
REQ-025 Macro MDU_DIV_EN: when defined, division SHALL be implemented as specified.
REQ-026 When MDU_DIV_EN is undefined, the divider datapath SHALL be absent, and a start with op=1 SHALL behave as REQ-020 (err set, hi/lo unchanged, done one cycle later); mult SHALL be unaffected.

Structure
REQ-027 Shared package mdu_pkg SHALL hold: the op encoding constants, move encoding constants (shared with the control decoder), the FSM state enum, XLEN=32, and ITER=32.
REQ-028 Sign handling (abs of each operand, conditional negate of the result) SHALL live in one sub-module, mdu_sign_fix; the FSM and datapath stay in mult_div_unit.

Verification
REQ-029 mult a=7, b=0xFFFFFFFD (-3): hi=0xFFFFFFFF, lo=0xFFFFFFEB, done exactly 34 cycles after the start edge, busy high 33 cycles.
REQ-030 mult a=b=0x80000000: hi=0x40000000, lo=0x00000000; then move=01 gives rdata=0x40000000 and move=10 gives rdata=0.
REQ-031 div a=0xFFFFFFF9 (-7), b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF, err=0; then div by 0x80000000/0xFFFFFFFF gives lo=0x80000000, hi=0.
REQ-032 div b=0 after the previous result: hi/lo unchanged, err=1, done 2 cycles after the start edge; the next start clears err.
REQ-033 Second start at cycle 10 of a mult: ignored, and the first result is correct; reset=0 at cycle 20: no done, hi=lo=0, IDLE.
REQ-034 Build without MDU_DIV_EN: div start gives err=1 with hi/lo unchanged, and REQ-029 still passes.
